// File: rtl/pipe_gen_pkg.sv
// pipe_gen shared types: FSM encoding, LFSR taps and default seed.
// Imported by the pipe_gen top and its lfsr8 sub-module.
package pipe_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        BUILD  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED  = 8'hA5;

    // Fibonacci step: feedback is b7^b5^b4^b3, shifted in at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_gen_if.sv
// Request/done handshake and column bundle between sequencer and pipe_gen.
// master = sequencer side, slave = generator side.
interface pipe_gen_if #(
    parameter int GS = 8
);
    logic          e_gen_i;
    logic [GS-1:0] col_o;
    logic          pipe_o;
    logic          d_gen_o;
    logic [7:0]    score_o;

    modport master (
        output e_gen_i,
        input  col_o,
        input  pipe_o,
        input  d_gen_o,
        input  score_o
    );

    modport slave (
        input  e_gen_i,
        output col_o,
        output pipe_o,
        output d_gen_o,
        output score_o
    );
endinterface

// File: rtl/pipe_gen_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, loads seed on reset, advances on step_i.
module lfsr8
    import pipe_gen_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       step_i,
    input  logic [7:0] seed,
    output logic [7:0] q_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) lfsr_q <= seed;
        else         lfsr_q <= lfsr_d;
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/pipe_gen.sv
// pipe_gen: obstacle column generator for the 8x8 playfield.
// Optional pipe score counter enabled by defining PIPE_GEN_SCORE_EN.
module pipe_gen
    import pipe_gen_pkg::*;
#(
    parameter int         GS      = 8,
    parameter int         GAP     = 3,
    parameter int         SPACING = 4,
    parameter logic [7:0] SEED    = DEF_SEED
) (
    input  logic        clk_i,
    input  logic        reset_i,
    pipe_gen_if.slave   gen
);

    localparam int         M        = GS - GAP + 1;
    localparam logic [7:0] M8       = 8'(M);
    localparam int         CW       = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPACING - 1);
    localparam logic [GS-1:0] GAP_ONES = {GS{1'b1}} >> (GS - GAP);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    r_q, r_d;
    logic          pflag_q, pflag_d;
    logic [GS-1:0] col_q, col_d;
    logic          pipe_q, pipe_d;
    logic          done_q, done_d;
    logic          step;
    logic [7:0]    lfsr_q;

    lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .step_i  (step),
        .seed    (SEED),
        .q_o     (lfsr_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        pflag_d = pflag_q;
        col_d   = col_q;
        pipe_d  = pipe_q;
        done_d  = done_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gen.e_gen_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        step    = 1'b1;
                        // r takes the value the LFSR moves to this edge
                        r_d     = lfsr_next(lfsr_q);
                        pflag_d = 1'b1;
                        state_d = REDUCE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        pflag_d = 1'b0;
                        state_d = BUILD;
                    end
                end
            end
            REDUCE: begin
                if (r_q >= M8) r_d = r_q - M8;
                else           state_d = BUILD;
            end
            BUILD: begin
                col_d   = pflag_q ? ~(GAP_ONES << r_q) : '0;
                pipe_d  = pflag_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!gen.e_gen_i) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            pflag_q <= 1'b0;
            col_q   <= '0;
            pipe_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            pflag_q <= pflag_d;
            col_q   <= col_d;
            pipe_q  <= pipe_d;
            done_q  <= done_d;
        end
    end

`ifdef PIPE_GEN_SCORE_EN
    logic [7:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (state_q == BUILD && pflag_q && score_q != 8'hFF)
            score_d = score_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) score_q <= 8'h00;
        else         score_q <= score_d;
    end

    assign gen.score_o = score_q;
`else
    assign gen.score_o = 8'h00;
`endif

    assign gen.col_o   = col_q;
    assign gen.pipe_o  = pipe_q;
    assign gen.d_gen_o = done_q;

endmodule

// File: doc/pipe_gen.md
# pipe_gen

Obstacle column generator for the 8x8 Flappy Bird playfield. On each request from the top-level sequencer it produces the next rightmost column for the action stage to shift in: either empty sky or a pipe, which is a lit wall with a pseudo-random vertical gap. It sits directly upstream of `action` and is driven by the same enable/done four-phase handshake style that the top-level state machine uses for its other stages.

## Interface

Parameters:
- `GS`, 8: playfield height in rows; width of `col_o`.
- `GAP`, 3: gap height in rows. Legal range is 1 ≤ GAP < GS.
- `SPACING`, 4: number of requests per pipe. Every SPACING-th column is a pipe; the rest are empty.
- `SEED`, 8'hA5: LFSR reset value. Must be non-zero.

Ports:
- `clk_i`, in, 1: clock. All logic is on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `e_gen_i`, in, 1: request, level-sensitive. Held high by the sequencer until `d_gen_o` is seen.
- `col_o`, out, GS: generated column. 1 means a lit wall pixel; bit 0 is the bottom row.
- `pipe_o`, out, 1: set when the last `col_o` is a pipe.
- `d_gen_o`, out, 1: done. Held high until `e_gen_i` drops.
- `score_o`, out, 8: count of pipes emitted. See Configuration.

## Operation

- Reset values: `col_o`=0, `pipe_o`=0, `d_gen_o`=0, `score_o`=0.
- Internal reset values: state IDLE, `cnt`=0, `lfsr`=SEED, `r`=0.
- Constant M = GS-GAP+1, the number of legal gap positions.
- LFSR: 8-bit Fibonacci. Feedback `fb` = b7^b5^b4^b3. Next value is {lfsr[6:0], fb}.
- States: IDLE, REDUCE, BUILD, DONE.
- **IDLE**, when `e_gen_i`=1:
  - If `cnt`==SPACING-1: set `cnt` to 0, step the LFSR, load `r` with the new LFSR value, set the pipe flag, go to REDUCE.
  - Otherwise: increment `cnt`, clear the pipe flag, go to BUILD.
- **REDUCE**: if `r` ≥ M, then `r` <= `r`-M and stay in REDUCE. Otherwise go to BUILD. Result: `r` = lfsr mod M.
- **BUILD**:
  - Pipe: `col_o` <= all ones with bits [r+GAP-1 : r] cleared.
  - Empty: `col_o` <= 0.
  - In both cases `pipe_o` <= pipe flag, `d_gen_o` <= 1, go to DONE.
- **DONE**: hold all outputs. When `e_gen_i`=0, `d_gen_o` <= 0 and go to IDLE.
- `col_o` and `pipe_o` stay stable from BUILD until the next BUILD.
- The LFSR steps only on pipe requests. Empty columns do not consume randomness.
- The gap always lies fully within the column: r+GAP-1 ≤ GS-1.
- `e_gen_i` is ignored in REDUCE and BUILD. Requests are never queued.

## Timing

- Request accepted in IDLE at cycle N:
  - Empty column: `d_gen_o` and `col_o` visible at N+2.
  - Pipe: visible at N+3+k, where k = floor(lfsr_new / M). Worst case is k=42 (lfsr=255, M=6), giving N+45.
- After `e_gen_i` falls, `d_gen_o` drops one cycle later. The earliest next accept is the cycle after that.
- `reset_i` overrides everything in the same edge, including mid-REDUCE or in DONE. No column is emitted for an aborted request.
- `cnt` wraps from SPACING-1 to 0. `score_o` saturates at 8'hFF.

## Configuration

- `PIPE_GEN_SCORE_EN` defined: `score_o` increments in BUILD for every pipe column. It resets to 0 and saturates at 255.
- Macro undefined: `score_o` is tied to 8'h00 and no counter logic is compiled. The port list is unchanged.

## Structure

- Shared package `pipe_gen_pkg` holds:
  - state encodings (IDLE, REDUCE, BUILD, DONE),
  - LFSR tap mask 8'hB8,
  - default SEED 8'hA5.
- Sub-module `lfsr8` has ports `clk_i`, `reset_i`, `step_i`, `seed`, `q_o`. It resets to `seed` and advances only while `step_i` is high.
- The FSM, modulo reducer and mask builder stay in `pipe_gen`.

## Test plan

- **Reset, then first three requests** with full handshakes → each gives `col_o`=8'h00, `pipe_o`=0, and `d_gen_o` 2 cycles after accept.
- **4th request** → LFSR 8'hA5→8'h4A, r=2, `col_o`=8'hE3, `pipe_o`=1, `d_gen_o` at N+15, `score_o`=1 (with macro).
- **8th request** → LFSR 8'h4A→8'h95, r=5, `col_o`=8'h1F, `score_o`=2. Build without the macro → `score_o` stays 0.
- **Hold `e_gen_i` high for 10 cycles after done** → `d_gen_o` stays 1 and no second column is generated. Drop it → `d_gen_o`=0 next cycle.
- **Assert `reset_i` mid-REDUCE** on the 4th request → all outputs 0. The next four requests repeat scenarios 1–2 exactly.
- **Parameters GS=8, GAP=7** (M=2) → 1000 random-timed handshakes; every pipe column has exactly 7 contiguous zeros starting at bit 0 or 1.
